// File: rtl/sd_image_arbiter_pkg.sv
// Shared types and helpers for the SD image arbiter.
package sd_image_arbiter_pkg;

  localparam int unsigned MAX_CHANNELS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sd_image_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or above ptr, wrapping.
module sd_image_arbiter_rr_pick #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned IW       = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [IW-1:0]       idx,
  output logic                valid
);

  logic [2*CHANNELS-1:0] req_dbl;
  logic [CHANNELS-1:0]   req_rot;
  int unsigned           off;
  int unsigned           sum;

  // Rotate so that bit 0 of req_rot is channel ptr; the doubled copy handles the wrap.
  assign req_dbl = {req, req};
  assign req_rot = CHANNELS'(req_dbl >> ptr);

  // Lowest set bit of the rotated vector, mapped back to an absolute channel.
  always_comb begin
    valid = 1'b0;
    off   = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!valid && req_rot[i]) begin
        valid = 1'b1;
        off   = i;
      end
    end
    sum = 32'(ptr) + off;
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    idx = IW'(sum);
  end

endmodule

// File: rtl/sd_image_arbiter.sv
// Round-robin, transaction-locked arbiter between SD image clients and the
// single user_io block-transfer port; also tracks per-image mount state.
// Optional ISSUE-phase timeout/abort is enabled by defining SD_ARB_TIMEOUT_EN.
module sd_image_arbiter
  import sd_image_arbiter_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned LBAW     = 32,
  parameter int unsigned TIMEOUT  = 2**20
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      cRd,
  input  logic [CHANNELS-1:0]      cWr,
  input  logic [CHANNELS*LBAW-1:0] cLba,
  input  logic [CHANNELS*8-1:0]    cBuffD,
  output logic [CHANNELS-1:0]      cAck,
  output logic [CHANNELS-1:0]      sdRd,
  output logic [CHANNELS-1:0]      sdWr,
  input  logic                     sdAck,
  output logic [LBAW-1:0]          sdLba,
  output logic [7:0]               sdBuffD,
  input  logic [CHANNELS-1:0]      imgMntd,
  input  logic [63:0]              imgSize,
  output logic [CHANNELS-1:0]      ready,
  output logic                     busy,
  output logic                     abort
);

  localparam int unsigned IW = idx_width(CHANNELS);

  state_t              state;
  logic [IW-1:0]       grant;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       next_ptr;
  logic [CHANNELS-1:0] req;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic [CHANNELS-1:0] pick_oh;
  logic [CHANNELS-1:0] grant_oh;
  logic                size_nz;

  assign req      = cRd | cWr;
  assign pick_oh  = CHANNELS'(1) << pick_idx;
  assign grant_oh = CHANNELS'(1) << grant;
  assign next_ptr = (32'(grant) == CHANNELS - 1) ? '0 : grant + IW'(1);
  assign size_nz  = (imgSize != 64'd0);

  // Write data path is a plain mux on the held grant so user_io sees it with no extra latency.
  assign sdBuffD = cBuffD[32'(grant)*8 +: 8];

  sd_image_arbiter_rr_pick #(
    .CHANNELS (CHANNELS),
    .IW       (IW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef SD_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          time_up;

  assign time_up = (32'(wait_cnt) == TIMEOUT - 1);
`else
  assign abort = 1'b0;
`endif

  // Transaction FSM: grant/latch in IDLE, request in ISSUE, route ack in XFER, advance pointer in DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      sdRd   <= '0;
      sdWr   <= '0;
      cAck   <= '0;
      sdLba  <= '0;
      busy   <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      abort    <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
`ifdef SD_ARB_TIMEOUT_EN
      abort    <= 1'b0;
      wait_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick_idx;
            sdLba <= cLba[32'(pick_idx)*LBAW +: LBAW];
            busy  <= 1'b1;
            // Read takes priority when a client raises both.
            if (cRd[pick_idx]) sdRd <= pick_oh;
            else               sdWr <= pick_oh;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (sdAck) begin
            sdRd  <= '0;
            sdWr  <= '0;
            cAck  <= grant_oh;
            state <= XFER;
          end
`ifdef SD_ARB_TIMEOUT_EN
          else if (time_up) begin
            sdRd  <= '0;
            sdWr  <= '0;
            abort <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        XFER: begin
          cAck <= sdAck ? grant_oh : '0;
          if (!sdAck) state <= DONE;
        end
        DONE: begin
          rr_ptr <= next_ptr;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mount tracking: every strobed slot takes the current size's nonzero-ness.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (imgMntd[i]) ready[i] <= size_nz;
      end
    end
  end

endmodule

// File: tb/tb_sd_image_arbiter.sv
// Directed bench for sd_image_arbiter (3 channels, 32-bit LBA, TIMEOUT=16).
module tb_sd_image_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   cRd = '0;
  logic [2:0]   cWr = '0;
  logic [95:0]  cLba;
  logic [23:0]  cBuffD;
  logic [2:0]   cAck;
  logic [2:0]   sdRd;
  logic [2:0]   sdWr;
  logic         sdAck = 1'b0;
  logic [31:0]  sdLba;
  logic [7:0]   sdBuffD;
  logic [2:0]   imgMntd = '0;
  logic [63:0]  imgSize = '0;
  logic [2:0]   ready;
  logic         busy;
  logic         abort;

  int n_checks = 0;
  int n_fail   = 0;

  assign cLba   = {32'h0000_0100, 32'h0000_0034, 32'h0000_0012};
  assign cBuffD = {8'hA5, 8'h5A, 8'h3C};

  always #5 clock = ~clock;

  sd_image_arbiter #(
    .CHANNELS (3),
    .LBAW     (32),
    .TIMEOUT  (16)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .cRd     (cRd),
    .cWr     (cWr),
    .cLba    (cLba),
    .cBuffD  (cBuffD),
    .cAck    (cAck),
    .sdRd    (sdRd),
    .sdWr    (sdWr),
    .sdAck   (sdAck),
    .sdLba   (sdLba),
    .sdBuffD (sdBuffD),
    .imgMntd (imgMntd),
    .imgSize (imgSize),
    .ready   (ready),
    .busy    (busy),
    .abort   (abort)
  );

  typedef struct {
    logic [2:0]  rd;
    logic [2:0]  wr;
    int          ack_len;
    logic [2:0]  exp_oh;
    logic        exp_wr;
    logic [31:0] exp_lba;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Step until the arbiter raises a request to user_io, at most 10 cycles.
  task automatic wait_issue(output int lat);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      lat++;
      if ((sdRd | sdWr) != 3'b000) break;
    end
  endtask

  // Hold sdAck for len cycles, verify the routed ack, then drain to idle.
  task automatic finish_xfer(input string name, input logic [2:0] oh, input int len);
    int hits;
    hits  = 0;
    sdAck = 1'b1;
    for (int k = 0; k < len; k++) begin
      tick();
      if (cAck == oh) hits++;
    end
    check({name, "_ack_cycles"}, 64'(hits), 64'(len));
    sdAck = 1'b0;
    cRd   = '0;
    cWr   = '0;
    tick();
    tick();
    check({name, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic do_vec(input int n, input vec_t v);
    int lat;
    int hits;
    int derr;
    string tag;
    tag = $sformatf("vec%0d", n);
    cRd = v.rd;
    cWr = v.wr;
    wait_issue(lat);
    check({tag, "_grant_latency_ok"}, 64'(lat <= 2), 64'd1);
    check({tag, "_sdRd"}, 64'(sdRd), 64'(v.exp_wr ? 3'b000 : v.exp_oh));
    check({tag, "_sdWr"}, 64'(sdWr), 64'(v.exp_wr ? v.exp_oh : 3'b000));
    check({tag, "_sdLba"}, 64'(sdLba), 64'(v.exp_lba));
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_cAck_pre"}, 64'(cAck), 64'd0);
    sdAck = 1'b1;
    hits  = 0;
    derr  = 0;
    for (int k = 0; k < v.ack_len; k++) begin
      tick();
      if (k == 0) check({tag, "_req_drop"}, 64'(sdRd | sdWr), 64'd0);
      if (cAck == v.exp_oh) hits++;
      if (sdBuffD != v.exp_d) derr++;
    end
    check({tag, "_cAck_cycles"}, 64'(hits), 64'(v.ack_len));
    check({tag, "_sdBuffD_errs"}, 64'(derr), 64'd0);
    sdAck = 1'b0;
    cRd   = '0;
    cWr   = '0;
    tick();
    check({tag, "_cAck_post"}, 64'(cAck), 64'd0);
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    tick();
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cnt;
    int bad;

    vecs[0] = '{3'b001, 3'b000, 512, 3'b001, 1'b0, 32'h12,  8'h3C};
    vecs[1] = '{3'b011, 3'b000, 5,   3'b010, 1'b0, 32'h34,  8'h5A};
    vecs[2] = '{3'b011, 3'b000, 6,   3'b001, 1'b0, 32'h12,  8'h3C};
    vecs[3] = '{3'b011, 3'b000, 4,   3'b010, 1'b0, 32'h34,  8'h5A};
    vecs[4] = '{3'b011, 3'b000, 3,   3'b001, 1'b0, 32'h12,  8'h3C};
    vecs[5] = '{3'b000, 3'b100, 8,   3'b100, 1'b1, 32'h100, 8'hA5};
    vecs[6] = '{3'b100, 3'b100, 2,   3'b100, 1'b0, 32'h100, 8'hA5};
    vecs[7] = '{3'b110, 3'b000, 1,   3'b010, 1'b0, 32'h34,  8'h5A};
    vecs[8] = '{3'b000, 3'b011, 3,   3'b001, 1'b1, 32'h12,  8'h3C};
    vecs[9] = '{3'b101, 3'b000, 2,   3'b100, 1'b0, 32'h100, 8'hA5};

    // Reset state
    tick();
    tick();
    check("rst_sdRd", 64'(sdRd), 64'd0);
    check("rst_sdWr", 64'(sdWr), 64'd0);
    check("rst_cAck", 64'(cAck), 64'd0);
    check("rst_sdLba", 64'(sdLba), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) do_vec(i, vecs[i]);

    // Mount tracking
    imgMntd = 3'b010; imgSize = 64'h2A000; tick();
    check("mnt_set1", 64'(ready), 64'b010);
    imgMntd = 3'b101; imgSize = 64'd5; tick();
    check("mnt_multi", 64'(ready), 64'b111);
    imgMntd = 3'b010; imgSize = 64'd0; tick();
    check("mnt_clear1", 64'(ready), 64'b101);
    imgMntd = 3'b000; imgSize = 64'd0; tick();
    check("mnt_nostrobe", 64'(ready), 64'b101);

`ifdef SD_ARB_TIMEOUT_EN
    // Timeout: ch0 never acked, pending ch1 served next
    cRd = 3'b011;
    tick();
    cnt = (sdRd == 3'b001) ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (sdRd == 3'b001) cnt++;
      else break;
    end
    check("to_issue_cycles", 64'(cnt), 64'd16);
    check("to_abort_pulse", 64'(abort), 64'd1);
    check("to_sdRd_drop", 64'(sdRd), 64'd0);
    tick();
    check("to_abort_end", 64'(abort), 64'd0);
    cRd = 3'b010;
    tick();
    check("to_next_grant", 64'(sdRd), 64'b010);
    finish_xfer("to_ch1", 3'b010, 2);
`else
    // No timeout: ISSUE holds the request indefinitely
    cRd = 3'b001;
    tick();
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (sdRd != 3'b001 || abort != 1'b0) bad++;
    end
    check("hold_issue_errs", 64'(bad), 64'd0);
    finish_xfer("hold_ch0", 3'b001, 2);
`endif

    // Client drops its request while ISSUE waits; transaction still completes
    cRd = 3'b001;
    tick();
    check("drop_grant", 64'(sdRd), 64'b001);
    cRd = 3'b000;
    tick();
    check("drop_still_issue", 64'(sdRd), 64'b001);
    finish_xfer("drop", 3'b001, 3);

    // Reset mid-transfer (round-robin pointer is 1 here)
    cWr = 3'b010;
    tick();
    check("rstx_grant", 64'(sdWr), 64'b010);
    sdAck = 1'b1;
    tick();
    tick();
    check("rstx_cAck_pre", 64'(cAck), 64'b010);
    #2 reset = 1'b1;
    #1;
    check("rstx_sdRd", 64'(sdRd), 64'd0);
    check("rstx_sdWr", 64'(sdWr), 64'd0);
    check("rstx_cAck", 64'(cAck), 64'd0);
    check("rstx_busy", 64'(busy), 64'd0);
    check("rstx_sdLba", 64'(sdLba), 64'd0);
    check("rstx_ready", 64'(ready), 64'd0);
    sdAck = 1'b0;
    cWr   = 3'b000;
    tick();
    reset = 1'b0;
    cRd = 3'b011;
    tick();
    check("rstx_ptr_reset", 64'(sdRd), 64'b001);
    finish_xfer("rstx_after", 3'b001, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
